// File: rtl/alu_pkg.sv
// Shared definitions for the registered datapath ALU: opcode encodings and default width.
// Optional feature macro: ALU_DIV_EN (enables opcode 5 as unsigned divide).
package alu_pkg;

  localparam int unsigned DEFAULT_WIDTH = 16;
  localparam int unsigned OP_W          = 3;

  localparam logic [OP_W-1:0] OP_ADD   = 3'd0;
  localparam logic [OP_W-1:0] OP_SUB   = 3'd1;
  localparam logic [OP_W-1:0] OP_MUL   = 3'd2;
  localparam logic [OP_W-1:0] OP_PASSB = 3'd3;
  localparam logic [OP_W-1:0] OP_INC   = 3'd4;
  localparam logic [OP_W-1:0] OP_DIV   = 3'd5;
  localparam logic [OP_W-1:0] OP_NOP6  = 3'd6;
  localparam logic [OP_W-1:0] OP_NOP7  = 3'd7;

endpackage

// File: rtl/alu_divider.sv
// Combinational unsigned restoring divider, quotient only; divide-by-zero yields all-ones.
// Only compiled when ALU_DIV_EN is defined, so the default build carries no divider.
`ifdef ALU_DIV_EN
module alu_divider
  import alu_pkg::*;
#(
  parameter int unsigned W = DEFAULT_WIDTH
) (
  input  logic [W-1:0] dividend,
  input  logic [W-1:0] divisor,
  output logic [W-1:0] quotient_c
);

  // Partial remainder carries one extra bit so the shifted value never overflows.
  logic [W:0] rem_c;

  // Shift-subtract one quotient bit per dividend bit, MSB first.
  always_comb begin
    rem_c      = '0;
    quotient_c = '0;
    if (divisor == '0) begin
      quotient_c = '1;
    end else begin
      for (int i = int'(W) - 1; i >= 0; i--) begin
        rem_c = {rem_c[W-1:0], dividend[i]};
        if (rem_c >= {1'b0, divisor}) begin
          rem_c         = rem_c - {1'b0, divisor};
          quotient_c[i] = 1'b1;
        end
      end
    end
  end

endmodule
`endif

// File: rtl/alu.sv
// Registered 16-bit arithmetic unit: one op per clock, result/zero flag/AC-load strobe
// registered with one cycle of latency. Synchronous active-high reset.
// Optional feature macro: ALU_DIV_EN (opcode 5 = unsigned divide; otherwise NOP).
module alu
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic [OP_W-1:0]  alu_control,
  output logic [WIDTH-1:0] out,
  output logic             zflag,
  output logic             ac_load
);

  logic [WIDTH-1:0] result_c;
  logic             write_c;

`ifdef ALU_DIV_EN
  logic [WIDTH-1:0] quotient_c;

  alu_divider #(
    .W (WIDTH)
  ) u_divider (
    .dividend   (in1),
    .divisor    (in2),
    .quotient_c (quotient_c)
  );
`endif

  // Operation select; non-writing opcodes leave write_c low so the registers hold.
  always_comb begin
    result_c = '0;
    write_c  = 1'b0;
    case (alu_control)
      OP_ADD: begin
        result_c = in1 + in2;
        write_c  = 1'b1;
      end
      OP_SUB: begin
        result_c = in1 - in2;
        write_c  = 1'b1;
      end
      OP_MUL: begin
        result_c = in1 * in2;
        write_c  = 1'b1;
      end
      OP_PASSB: begin
        result_c = in2;
        write_c  = 1'b1;
      end
      OP_INC: begin
        result_c = in1 + WIDTH'(1);
        write_c  = 1'b1;
      end
`ifdef ALU_DIV_EN
      OP_DIV: begin
        result_c = quotient_c;
        write_c  = 1'b1;
      end
`endif
      OP_NOP6, OP_NOP7: begin
        write_c = 1'b0;
      end
      default: begin
        write_c = 1'b0;
      end
    endcase
  end

  // Result, zero flag and load strobe registers; reset discards the op sampled with it.
  always_ff @(posedge clk) begin
    if (rst) begin
      out     <= '0;
      zflag   <= 1'b0;
      ac_load <= 1'b0;
    end else begin
      ac_load <= write_c;
      if (write_c) begin
        out   <= result_c;
        zflag <= (result_c == '0);
      end
    end
  end

endmodule

// File: tb/tb_alu.sv
// Directed scoreboard bench for alu: each step drives inputs on the falling edge, pushes
// the model's expected outputs, and checks them 1 time unit after the next rising edge.
// Honours ALU_DIV_EN the same way the design does.
module tb_alu;

  localparam int unsigned W = 16;

  typedef struct packed {
    logic [W-1:0] out;
    logic         z;
    logic         ac;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [W-1:0] in1 = '0;
  logic [W-1:0] in2 = '0;
  logic [2:0]   alu_control = 3'd6;
  logic [W-1:0] out;
  logic         zflag;
  logic         ac_load;

  exp_t exp_q[$];

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference model state (what out/zflag should currently hold).
  logic [W-1:0] m_out = '0;
  logic         m_z   = 1'b0;

  alu dut (
    .clk         (clk),
    .rst         (rst),
    .in1         (in1),
    .in2         (in2),
    .alu_control (alu_control),
    .out         (out),
    .zflag       (zflag),
    .ac_load     (ac_load)
  );

  always #5 clk = ~clk;

  task automatic step(input logic r, input logic [2:0] op, input logic [W-1:0] a,
                      input logic [W-1:0] b, input string tag);
    exp_t        e;
    logic        wr;
    logic [W-1:0] res;
    @(negedge clk);
    rst = r; alu_control = op; in1 = a; in2 = b;
    wr  = 1'b1;
    res = '0;
    case (op)
      3'd0: res = a + b;
      3'd1: res = a - b;
      3'd2: res = a * b;
      3'd3: res = b;
      3'd4: res = a + 16'd1;
`ifdef ALU_DIV_EN
      3'd5: res = (b == 16'd0) ? 16'hFFFF : a / b;
`endif
      default: wr = 1'b0;
    endcase
    if (r) begin
      m_out = '0; m_z = 1'b0; wr = 1'b0;
    end else if (wr) begin
      m_out = res; m_z = (res == 16'd0);
    end
    exp_q.push_back('{out: m_out, z: m_z, ac: wr});

    @(posedge clk);
    #1;
    n_cmp++;
    assert (exp_q.size() != 0) else begin
      n_fail++;
      $error("FAIL %s scoreboard empty observed=0 expected=1", tag);
    end
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      n_cmp++;
      assert (out === e.out) else begin
        n_fail++;
        $error("FAIL %s out observed=%h expected=%h", tag, out, e.out);
      end
      n_cmp++;
      assert (zflag === e.z) else begin
        n_fail++;
        $error("FAIL %s zflag observed=%b expected=%b", tag, zflag, e.z);
      end
      n_cmp++;
      assert (ac_load === e.ac) else begin
        n_fail++;
        $error("FAIL %s ac_load observed=%b expected=%b", tag, ac_load, e.ac);
      end
    end
  endtask

  initial begin
    step(1'b1, 3'd0, 16'd5,     16'd7,     "reset");
    step(1'b0, 3'd0, 16'd5,     16'd7,     "add_5_7");
    step(1'b0, 3'd1, 16'd5,     16'd7,     "sub_5_7");
    step(1'b0, 3'd1, 16'd3,     16'd10,    "sub_3_10");
    step(1'b0, 3'd2, 16'd3,     16'd10,    "mul_3_10");
    step(1'b0, 3'd2, 16'h0100,  16'h0100,  "mul_wrap_zero");
    step(1'b0, 3'd6, 16'h1111,  16'h2222,  "nop6_holds_z1");
    step(1'b0, 3'd0, 16'h1234,  16'h4321,  "add_held_a");
    step(1'b0, 3'd0, 16'h1234,  16'h4321,  "add_held_b");
    step(1'b0, 3'd0, 16'hFFFF,  16'h0001,  "add_wrap");
    step(1'b0, 3'd4, 16'hFFFF,  16'h5A5A,  "inc_wrap");
    step(1'b0, 3'd4, 16'h0010,  16'h0000,  "inc_16");
    step(1'b0, 3'd3, 16'hBEEF,  16'h1234,  "passb");
    step(1'b0, 3'd6, 16'h0000,  16'h0000,  "nop6");
    step(1'b0, 3'd7, 16'hFFFF,  16'hFFFF,  "nop7");
    step(1'b0, 3'd5, 16'd5,     16'd2,     "op5_5_2");
    step(1'b0, 3'd5, 16'd7,     16'd0,     "op5_7_0");
    step(1'b0, 3'd5, 16'hFFFF,  16'd3,     "op5_ffff_3");
    step(1'b0, 3'd5, 16'd0,     16'd5,     "op5_0_5");
    step(1'b0, 3'd3, 16'h0000,  16'h00AA,  "passb_pre_rst");
    step(1'b1, 3'd0, 16'd100,   16'd23,    "rst_mid_stream");
    step(1'b0, 3'd6, 16'd100,   16'd23,    "after_rst_hold");
    step(1'b0, 3'd1, 16'h8000,  16'h8000,  "sub_equal");
    for (int i = 0; i < 24; i++) begin
      step(1'b0, 3'($urandom_range(0, 7)), 16'($urandom), 16'($urandom_range(0, 300)),
           "random");
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
